flash_ctrl: RTL

FLASH_CTRL -- requirements
Module: flash_ctrl

---
 rtl/flash_pkg.sv | 21 ++
 rtl/flash_tick_cnt.sv | 30 +++
 rtl/flash_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Purpose: shared mode and state encodings for the flash attribute controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flash_pkg;

    // Operating mode selected by the host
    typedef enum logic [1:0] {
        MODE_STEADY_ON  = 2'b00,
        MODE_BLINK      = 2'b01,
        MODE_BURST      = 2'b10,
        MODE_STEADY_OFF = 2'b11
    } mode_e;

    // Phase sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10
    } state_e;

endpackage

// File: rtl/flash_tick_cnt.sv
// Purpose: loadable down-counter measuring one flash phase in prescaler ticks.
// Latency: load/decrement visible one cycle later; last is combinational from the count.
// Backpressure: none; load has priority over dec, and the count saturates at zero.
module flash_tick_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] value,
    input  logic          dec,
    output logic          last
);

    logic [CW-1:0] r_count;

    // Count register: load wins, otherwise step down without going below zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign last = (r_count == CW'(1));

endmodule

// File: rtl/flash_ctrl.sv
// Purpose: blink/burst flash attribute sequencer with frame-synchronised visible output.
// Latency: raw phase updates one cycle after the terminating tick; visible follows at the next frame_start.
// Backpressure: none; start is dropped when busy or outside BURST mode.
module flash_ctrl
    import flash_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          frame_start,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] on_ticks,
    input  logic [CW-1:0] off_ticks,
    input  logic [CW-1:0] burst_cnt,
    input  logic          start,
    output logic          visible,
    output logic          busy,
    output logic          done
);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [1:0]    r_seq_mode;
    logic [1:0]    w_seq_mode_nxt;
    logic [CW-1:0] r_rem;
    logic [CW-1:0] w_rem_nxt;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_dec;
    logic          w_last;
    logic          w_done_nxt;
    logic          w_raw_nxt;
    logic          r_raw;
    logic          r_visible;
    logic          r_done;
    logic [CW-1:0] w_on_len;
    logic [CW-1:0] w_off_len;

    // A programmed length of zero behaves as a single tick
    assign w_on_len  = (on_ticks  == '0) ? CW'(1) : on_ticks;
    assign w_off_len = (off_ticks == '0) ? CW'(1) : off_ticks;

    // Ticks only consume phase time while a sequence is running
    assign w_dec = tick && (r_state != ST_IDLE);

    flash_tick_cnt #(.CW(CW)) u_tick_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (w_load),
        .value (w_load_val),
        .dec   (w_dec),
        .last  (w_last)
    );

    // State register with the sequence mode and remaining burst cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_seq_mode <= MODE_STEADY_ON;
            r_rem      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_seq_mode <= w_seq_mode_nxt;
            r_rem      <= w_rem_nxt;
        end
    end

    // Next-state decode, counter load control and burst bookkeeping
    always_comb begin
        w_state_nxt    = r_state;
        w_seq_mode_nxt = r_seq_mode;
        w_rem_nxt      = r_rem;
        w_load         = 1'b0;
        w_load_val     = w_on_len;
        w_done_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mode == MODE_BLINK) begin
                    w_state_nxt    = ST_ON;
                    w_seq_mode_nxt = mode;
                    w_load         = 1'b1;
                end else if ((mode == MODE_BURST) && start) begin
                    if (burst_cnt == '0) begin
                        // Empty burst completes immediately without running a phase
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = ST_ON;
                        w_seq_mode_nxt = mode;
                        w_rem_nxt      = burst_cnt;
                        w_load         = 1'b1;
                    end
                end
            end
            ST_ON: begin
                if (mode != r_seq_mode) begin
                    w_state_nxt = ST_IDLE;
                    w_rem_nxt   = '0;
                end else if (tick && w_last) begin
                    w_state_nxt = ST_OFF;
                    w_load      = 1'b1;
                    w_load_val  = w_off_len;
                end
            end
            ST_OFF: begin
                if (mode != r_seq_mode) begin
                    w_state_nxt = ST_IDLE;
                    w_rem_nxt   = '0;
                end else if (tick && w_last) begin
                    if (r_seq_mode == MODE_BLINK) begin
                        w_state_nxt = ST_ON;
                        w_load      = 1'b1;
                    end else if (r_rem <= CW'(1)) begin
                        // Final OFF phase of the burst
                        w_state_nxt = ST_IDLE;
                        w_rem_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_ON;
                        w_rem_nxt   = r_rem - CW'(1);
                        w_load      = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Raw phase bit implied by the upcoming state
    always_comb begin
        w_raw_nxt = 1'b1;
        case (w_state_nxt)
            ST_ON:   w_raw_nxt = 1'b1;
            ST_OFF:  w_raw_nxt = 1'b0;
            default: w_raw_nxt = (mode != MODE_STEADY_OFF);
        endcase
    end

    // Output registers: raw phase, done pulse, and visible sampled only at frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_raw     <= 1'b1;
            r_visible <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_raw  <= w_raw_nxt;
            r_done <= w_done_nxt;
            if (frame_start) begin
                r_visible <= r_raw;
            end
        end
    end

    assign visible = r_visible;
    assign busy    = (r_state == ST_ON) || (r_state == ST_OFF);
    assign done    = r_done;

endmodule
